// File: rtl/key_sched_ctrl.sv
//==============================================================================
// key_sched_ctrl : AES-128 round-key schedule sequencer and key store
// Revision 1.0
//==============================================================================
`default_nettype none

module key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] ex_k_i,
  output logic [31:0]  ex_rcon,
  input  logic [127:0] ex_r_k,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         done,
  output logic         key_valid
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t       state;
  state_t       next_state;
  logic [3:0]   round;
  logic [127:0] work;
  logic [127:0] slots [0:NR];
  logic         done_q;
  logic         key_valid_q;

  function automatic logic [7:0] rc_of(input logic [3:0] r);
    case (r)
      4'd1:    rc_of = 8'h01;
      4'd2:    rc_of = 8'h02;
      4'd3:    rc_of = 8'h04;
      4'd4:    rc_of = 8'h08;
      4'd5:    rc_of = 8'h10;
      4'd6:    rc_of = 8'h20;
      4'd7:    rc_of = 8'h40;
      4'd8:    rc_of = 8'h80;
      4'd9:    rc_of = 8'h1b;
      4'd10:   rc_of = 8'h36;
      default: rc_of = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ex_k_i     = '0;
    ex_rcon    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        ex_k_i  = work;
        ex_rcon = {rc_of(round), 24'h0};
        if (round == LAST_ROUND) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Round counter stops at NR on completion, so it never exceeds NR.
  always_ff @(posedge clk) begin
    if (rst) begin
      round       <= '0;
      work        <= '0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        slots[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            slots[0]    <= key_in;
            work        <= key_in;
            round       <= 4'd1;
            key_valid_q <= 1'b0;
          end
        end
        EXPAND: begin
          work <= ex_r_k;
          for (int i = 1; i <= NR; i++) begin
            if (round == 4'(i)) begin
              slots[i] <= ex_r_k;
            end
          end
          if (round == LAST_ROUND) begin
            done_q      <= 1'b1;
            key_valid_q <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_addr == 4'(i)) begin
        rd_key = slots[i];
      end
    end
  end

  assign busy      = (state == EXPAND);
  assign done      = done_q;
  assign key_valid = key_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_key_sched_ctrl.sv
//==============================================================================
// tb_key_sched_ctrl : directed self-checking bench with an AES expansion model
//==============================================================================
`default_nettype none

module tb_key_sched_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_S1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_S10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_S10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] ex_k_i;
  logic [31:0]  ex_rcon;
  logic [127:0] ex_r_k;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  logic         busy;
  logic         done;
  logic         key_valid;

  int total = 0;
  int bad   = 0;
  logic [127:0] ref_a [0:NR];

  key_sched_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .ex_k_i(ex_k_i), .ex_rcon(ex_rcon), .ex_r_k(ex_r_k),
    .rd_addr(rd_addr), .rd_key(rd_key),
    .busy(busy), .done(done), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return SBOX[2047 - 8*idx -: 8];
  endfunction

  function automatic logic [127:0] expand_step(input logic [127:0] k, input logic [31:0] rcon);
    logic [31:0] w3r, t, n0, n1, n2, n3;
    w3r = {k[23:0], k[31:24]};
    t   = {sub_byte(w3r[31:24]), sub_byte(w3r[23:16]),
           sub_byte(w3r[15:8]), sub_byte(w3r[7:0])} ^ rcon;
    n0  = k[127:96] ^ t;
    n1  = k[95:64]  ^ n0;
    n2  = k[63:32]  ^ n1;
    n3  = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [7:0] rc_ref(input int r);
    logic [79:0] tbl;
    tbl = 80'h01020408102040801b36;
    return tbl[79 - 8*(r-1) -: 8];
  endfunction

  always_comb ex_r_k = expand_step(ex_k_i, ex_rcon);

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [127:0] exp);
    rd_addr = 4'(addr);
    #1;
    check_val($sformatf("%s[%0d]", tag, addr), rd_key, exp);
  endtask

  // Launches a schedule from IDLE and walks it to the DONE cycle.
  task automatic run_sched(input logic [127:0] key, input bit poke, input string tag);
    start  = 1'b1;
    key_in = key;
    tick();
    start  = 1'b0;
    check_val({tag, "_busy"}, 128'(busy), 128'd1);
    check_val({tag, "_kv_clr"}, 128'(key_valid), 128'd0);
    check_val({tag, "_ex_k_i"}, ex_k_i, key);
    for (int k = 1; k <= NR; k++) begin
      check_val($sformatf("%s_rcon%0d", tag, k), 128'(ex_rcon), 128'({rc_ref(k), 24'h0}));
      check_val($sformatf("%s_nodone%0d", tag, k), 128'(done), 128'd0);
      if (poke && (k == 3 || k == 7)) begin
        start  = 1'b1;
        key_in = ~key;
      end
      tick();
      start = 1'b0;
    end
    check_val({tag, "_done"}, 128'(done), 128'd1);
    check_val({tag, "_kv"}, 128'(key_valid), 128'd1);
    check_val({tag, "_idle"}, 128'(busy), 128'd0);
    check_val({tag, "_rcon_idle"}, 128'(ex_rcon), 128'd0);
    check_val({tag, "_kin_idle"}, ex_k_i, 128'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    key_in  = '0;
    rd_addr = '0;
    ref_a[0] = KEY_A;
    for (int k = 1; k <= NR; k++) begin
      ref_a[k] = expand_step(ref_a[k-1], {rc_ref(k), 24'h0});
    end

    tick();
    tick();
    check_val("rst_busy", 128'(busy), 128'd0);
    check_val("rst_done", 128'(done), 128'd0);
    check_val("rst_kv", 128'(key_valid), 128'd0);
    check_val("rst_rcon", 128'(ex_rcon), 128'd0);
    read_chk("rst_slot", 0, 128'd0);
    rst = 1'b0;
    tick();

    // Plain schedule with key A
    run_sched(KEY_A, 1'b0, "a");
    tick();
    check_val("a_done_pulse", 128'(done), 128'd0);
    check_val("a_kv_hold", 128'(key_valid), 128'd1);
    read_chk("a_slot", 0, KEY_A);
    read_chk("a_slot", 1, A_S1);
    read_chk("a_slot", 10, A_S10);
    for (int k = 2; k < NR; k++) read_chk("a_model", k, ref_a[k]);
    for (int a = 11; a <= 15; a++) read_chk("a_oob", a, 128'd0);

    // START pulses during EXPAND must be ignored
    run_sched(KEY_A, 1'b1, "p");
    tick();
    check_val("p_done_pulse", 128'(done), 128'd0);
    check_val("p_still_idle", 128'(busy), 128'd0);
    read_chk("p_slot", 0, KEY_A);
    read_chk("p_slot", 1, A_S1);
    read_chk("p_slot", 10, A_S10);

    // Reset in the middle of round 5
    start  = 1'b1;
    key_in = KEY_A;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check_val("r_round5_rcon", 128'(ex_rcon), 128'h10000000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("r_busy", 128'(busy), 128'd0);
    check_val("r_kv", 128'(key_valid), 128'd0);
    check_val("r_done", 128'(done), 128'd0);
    read_chk("r_slot", 0, 128'd0);
    read_chk("r_slot", 1, 128'd0);
    read_chk("r_slot", 4, 128'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val($sformatf("r_nodone%0d", k), 128'(done), 128'd0);
    end
    run_sched(KEY_A, 1'b0, "ra");
    read_chk("ra_slot", 1, A_S1);
    read_chk("ra_slot", 10, A_S10);

    // Back-to-back: START in the DONE cycle
    start  = 1'b1;
    key_in = KEY_B;
    tick();
    start = 1'b0;
    check_val("b2b_done_once", 128'(done), 128'd0);
    check_val("b2b_busy", 128'(busy), 128'd1);
    check_val("b2b_kv_clr", 128'(key_valid), 128'd0);
    for (int k = 1; k <= NR; k++) tick();
    check_val("b2b_done", 128'(done), 128'd1);
    read_chk("b2b_slot", 0, KEY_B);
    read_chk("b2b_slot", 10, B_S10);
    tick();
    check_val("b2b_done_pulse", 128'(done), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
